full_adder: RTL and testbench



---
 rtl/full_adder.sv | 58 +++++
 tb/tb_full_adder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// One-bit full adder with a registered, bit-serial mode. The combinational
// sum/carry outputs serve ripple chains. The internal carry register lets one cell add LSB-first streams.
module full_adder (
  input  logic clk,
  input  logic rst,
  input  logic x,
  input  logic y,
  input  logic carry_in,
  input  logic serial,
  input  logic en,
  input  logic clear,
  output logic sum,
  output logic carry,
  output logic sum_q,
  output logic carry_q,
  output logic valid_q
);

  logic r_cstate;
  logic r_sum;
  logic r_carry;
  logic r_valid;
  logic w_cin;
  logic w_sum;
  logic w_carry;

  // An AND/OR mux passes an X on serial through to the outputs. A ?: mux would hide it when both inputs agree.
  assign w_cin   = (serial & r_cstate) | (~serial & carry_in);
  assign w_sum   = x ^ y ^ w_cin;
  assign w_carry = (x & y) | (x & w_cin) | (y & w_cin);

  assign sum     = w_sum;
  assign carry   = w_carry;
  assign sum_q   = r_sum;
  assign carry_q = r_carry;
  assign valid_q = r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum    <= 1'b0;
      r_carry  <= 1'b0;
      r_valid  <= 1'b0;
      r_cstate <= 1'b0;
    end else if (en) begin
      r_sum    <= w_sum;
      r_carry  <= w_carry;
      r_valid  <= 1'b1;
      // A capture with clear still lands. Only the carry kept for the next bit is dropped.
      r_cstate <= clear ? 1'b0 : w_carry;
    end else begin
      r_valid <= 1'b0;
      if (clear) begin
        r_cstate <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder. Expected registered results are queued when a capture is driven.
// They are popped and compared one cycle later.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst, x, y, carry_in, serial, en, clear;
  logic sum, carry, sum_q, carry_q, valid_q;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];
  logic       m_cstate;
  logic       m_sq;
  logic       m_cq;

  full_adder dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .carry_in(carry_in),
    .serial(serial), .en(en), .clear(clear),
    .sum(sum), .carry(carry), .sum_q(sum_q), .carry_q(carry_q), .valid_q(valid_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at the falling edge, check the combinational outputs, then check the registered outputs after the rising edge.
  task automatic step(input logic a, input logic b, input logic ci, input logic ser,
                      input logic e, input logic clr, input string tag, output logic sq);
    logic cin_m, s_m, c_m;
    logic [1:0] popped;
    @(negedge clk);
    x = a; y = b; carry_in = ci; serial = ser; en = e; clear = clr;
    #1;
    cin_m = ser ? m_cstate : ci;
    s_m   = a ^ b ^ cin_m;
    c_m   = (a & b) | (a & cin_m) | (b & cin_m);
    chk({tag, ".sum"}, {15'd0, sum}, {15'd0, s_m});
    chk({tag, ".carry"}, {15'd0, carry}, {15'd0, c_m});
    if (e) exp_q.push_back({s_m, c_m});
    @(posedge clk);
    if (e) m_cstate = clr ? 1'b0 : c_m;
    else if (clr) m_cstate = 1'b0;
    #1;
    if (e) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $error("FAIL %s.queue observed=empty expected=entry", tag);
      end else begin
        popped = exp_q.pop_front();
        m_sq = popped[1];
        m_cq = popped[0];
      end
    end
    chk({tag, ".sum_q"}, {15'd0, sum_q}, {15'd0, m_sq});
    chk({tag, ".carry_q"}, {15'd0, carry_q}, {15'd0, m_cq});
    chk({tag, ".valid_q"}, {15'd0, valid_q}, {15'd0, e});
    sq = sum_q;
  endtask

  task automatic serial_add(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] exp_sum, input logic exp_cout, input string tag);
    logic [15:0] res;
    logic bit_q;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, {tag, ".clr"}, bit_q);
    for (int i = 0; i < 16; i++) begin
      step(a[i], b[i], 1'b0, 1'b1, 1'b1, 1'b0, $sformatf("%s.b%0d", tag, i), bit_q);
      res[i] = bit_q;
    end
    chk({tag, ".word"}, res, exp_sum);
    chk({tag, ".cout"}, {15'd0, carry_q}, {15'd0, exp_cout});
    $display("serial %s: %04h + %04h -> %04h carry %0b", tag, a, b, res, carry_q);
  endtask

  initial begin
    logic dummy;
    logic [2:0] v;
    rst = 1'b1; x = 1'b0; y = 1'b0; carry_in = 1'b0; serial = 1'b0; en = 1'b0; clear = 1'b0;
    m_cstate = 1'b0; m_sq = 1'b0; m_cq = 1'b0;
    #3;
    chk("reset.sum_q", {15'd0, sum_q}, 16'd0);
    chk("reset.carry_q", {15'd0, carry_q}, 16'd0);
    chk("reset.valid_q", {15'd0, valid_q}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Exhaustive parallel truth table, with the four anchor rows checked as literals as well.
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      step(v[2], v[1], v[0], 1'b0, 1'b0, 1'b0, $sformatf("tt%0d", i), dummy);
      if (i == 0) begin chk("tt000.lit", {14'd0, sum, carry}, 16'b00); end
      if (i == 1) begin chk("tt001.lit", {14'd0, sum, carry}, 16'b10); end
      if (i == 3) begin chk("tt011.lit", {14'd0, sum, carry}, 16'b01); end
      if (i == 7) begin chk("tt111.lit", {14'd0, sum, carry}, 16'b11); end
      $display("truth x=%0b y=%0b cin=%0b -> sum=%0b carry=%0b", v[2], v[1], v[0], sum, carry);
    end

    // Seed cstate=1, then assert an asynchronous reset in the middle of an enabled cycle.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "seed", dummy);
    @(negedge clk);
    x = 1'b1; y = 1'b1; en = 1'b1; serial = 1'b0; carry_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_async.sum_q", {15'd0, sum_q}, 16'd0);
    chk("rst_async.carry_q", {15'd0, carry_q}, 16'd0);
    chk("rst_async.valid_q", {15'd0, valid_q}, 16'd0);
    $display("async reset: sum_q=%0b carry_q=%0b valid_q=%0b", sum_q, carry_q, valid_q);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_cstate = 1'b0; m_sq = 1'b0; m_cq = 1'b0;
    x = 1'b1; y = 1'b0; serial = 1'b1; en = 1'b0;
    #1;
    chk("rst_cstate.sum", {15'd0, sum}, 16'd1);
    chk("rst_cstate.carry", {15'd0, carry}, 16'd0);

    serial_add(16'hFFFF, 16'h0001, 16'h0000, 1'b1, "ffff_1");
    serial_add(16'd1234, 16'd4321, 16'd5555, 1'b0, "1234_4321");

    // Capture 1+1, then hold for three cycles while the inputs toggle.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "hold.cap", dummy);
    chk("hold.cap_lit", {14'd0, sum_q, carry_q}, 16'b01);
    for (int i = 0; i < 3; i++) begin
      step(i[0], ~i[0], i[1], 1'b0, 1'b0, 1'b0, $sformatf("hold%0d", i), dummy);
      chk($sformatf("hold%0d.lit", i), {13'd0, sum_q, carry_q, valid_q}, 16'b010);
      $display("hold cycle %0d: sum_q=%0b carry_q=%0b valid_q=%0b", i, sum_q, carry_q, valid_q);
    end
    @(negedge clk);
    x = 1'b0; y = 1'b0; serial = 1'b1; en = 1'b0; clear = 1'b0;
    #1;
    chk("hold.cstate", {14'd0, sum, carry}, 16'b10);

    // Clear together with en: this bit still sees cstate=1, and the next bit sees 0.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "clr_en", dummy);
    chk("clr_en.lit", {14'd0, sum_q, carry_q}, 16'b01);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "after_clr", dummy);
    chk("after_clr.lit", {15'd0, sum_q}, 16'd0);
    $display("clear with en: next sum_q=%0b carry_q=%0b", sum_q, carry_q);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
